// File: rtl/stream_demux2.sv
// -----------------------------------------------------------------------------
// stream_demux2
//
// Purpose:
//   1-to-2 stream demultiplexer. Each input beat carries a select bit that
//   steers it to lane A (IN_S=0) or lane B (IN_S=1). Each lane owns a 2-entry
//   registered FIFO (head/tail) with its own valid/ready handshake. A stalled
//   lane therefore never blocks, corrupts or reorders traffic on the other.
//
// Ports:
//   CLK       in   rising-edge clock
//   RST       in   synchronous active-high reset
//   IN_DATA   in   input beat payload (WIDTH bits)
//   IN_S      in   lane select, qualified by IN_VALID (0 = A, 1 = B)
//   IN_VALID  in   input beat present
//   IN_READY  out  beat accepted this cycle (selected lane not full)
//   A_DATA    out  lane A head payload
//   A_VALID   out  lane A holds at least one beat
//   A_READY   in   lane A consumer accepts
//   B_DATA    out  lane B head payload
//   B_VALID   out  lane B holds at least one beat
//   B_READY   in   lane B consumer accepts
//   A_CNT     out  lane A pop counter, 16 bits (only with STREAM_DEMUX2_CNT_EN)
//   B_CNT     out  lane B pop counter, 16 bits (only with STREAM_DEMUX2_CNT_EN)
//
// Optional feature macro: STREAM_DEMUX2_CNT_EN
//   When defined, adds the per-lane wrapping pop counters A_CNT and B_CNT.
// -----------------------------------------------------------------------------
module stream_demux2 #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_S,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] A_DATA,
  output logic             A_VALID,
  input  logic             A_READY,
  output logic [WIDTH-1:0] B_DATA,
  output logic             B_VALID,
  input  logic             B_READY
`ifdef STREAM_DEMUX2_CNT_EN
  ,
  output logic [15:0]      A_CNT,
  output logic [15:0]      B_CNT
`endif
);

  // Occupancy of one lane; doubles as the lane's FIFO state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } laneState_t;

  // Index 0 is lane A, index 1 is lane B.
  laneState_t       state_q [2];
  laneState_t       state_d [2];
  logic [WIDTH-1:0] head_q  [2];
  logic [WIDTH-1:0] head_d  [2];
  logic [WIDTH-1:0] tail_q  [2];
  logic [WIDTH-1:0] tail_d  [2];

  logic [1:0] notFull;
  logic [1:0] laneSel;
  logic [1:0] laneReady;
  logic [1:0] push;
  logic [1:0] pop;

  // Handshake decode. IN_READY only looks at the lane IN_S points to, so a
  // full lane stalls the producer only for beats aimed at that lane.
  always_comb begin
    notFull   = {state_q[1] != FULL, state_q[0] != FULL};
    laneSel   = {IN_S, ~IN_S};
    laneReady = {B_READY, A_READY};
    IN_READY  = IN_S ? notFull[1] : notFull[0];
    push      = laneSel & notFull & {2{IN_VALID}};
    pop       = {state_q[1] != EMPTY, state_q[0] != EMPTY} & laneReady;
  end

  // Per-lane FIFO next state. A push into an occupied lane lands in the tail,
  // except when the head leaves on the same edge: then the new beat becomes
  // the head directly and the occupancy does not change. Push at FULL cannot
  // happen because IN_READY is low for that lane.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      state_d[l] = state_q[l];
      head_d[l]  = head_q[l];
      tail_d[l]  = tail_q[l];
      case ({push[l], pop[l]})
        2'b10: begin
          if (state_q[l] == EMPTY) begin
            head_d[l]  = IN_DATA;
            state_d[l] = ONE;
          end else begin
            tail_d[l]  = IN_DATA;
            state_d[l] = FULL;
          end
        end
        2'b01: begin
          if (state_q[l] == FULL) begin
            head_d[l]  = tail_q[l];
            state_d[l] = ONE;
          end else begin
            state_d[l] = EMPTY;
          end
        end
        2'b11: begin
          head_d[l] = IN_DATA;
        end
        default: ;
      endcase
    end
  end

  // Lane storage. Reset discards every buffered beat and zeroes the entries
  // so both data outputs read 0 after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int l = 0; l < 2; l++) begin
        state_q[l] <= EMPTY;
        head_q[l]  <= '0;
        tail_q[l]  <= '0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        state_q[l] <= state_d[l];
        head_q[l]  <= head_d[l];
        tail_q[l]  <= tail_d[l];
      end
    end
  end

  assign A_DATA  = head_q[0];
  assign B_DATA  = head_q[1];
  assign A_VALID = (state_q[0] != EMPTY);
  assign B_VALID = (state_q[1] != EMPTY);

`ifdef STREAM_DEMUX2_CNT_EN
  logic [15:0] popCntA_q;
  logic [15:0] popCntB_q;
  logic [15:0] popCntA_d;
  logic [15:0] popCntB_d;

  // Pop counters wrap naturally at 16 bits.
  always_comb begin
    popCntA_d = popCntA_q + {15'd0, pop[0]};
    popCntB_d = popCntB_q + {15'd0, pop[1]};
  end

  // Counters register on the same edge as the pop they count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      popCntA_q <= '0;
      popCntB_q <= '0;
    end else begin
      popCntA_q <= popCntA_d;
      popCntB_q <= popCntB_d;
    end
  end

  assign A_CNT = popCntA_q;
  assign B_CNT = popCntB_q;
`endif

endmodule

// File: tb/tb_stream_demux2.sv
// -----------------------------------------------------------------------------
// tb_stream_demux2
//
// Purpose:
//   Directed self-checking bench for stream_demux2 (WIDTH=8). Inputs change
//   1 time unit after each rising edge; outputs are sampled 1 time unit after
//   that, well clear of the active edge.
//
// Optional feature macro: STREAM_DEMUX2_CNT_EN (enables the pop counter test).
// -----------------------------------------------------------------------------
module tb_stream_demux2;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] IN_DATA;
  logic       IN_S;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] A_DATA;
  logic       A_VALID;
  logic       A_READY;
  logic [7:0] B_DATA;
  logic       B_VALID;
  logic       B_READY;
`ifdef STREAM_DEMUX2_CNT_EN
  logic [15:0] A_CNT;
  logic [15:0] B_CNT;
`endif

  int errors = 0;
  int checks = 0;

  stream_demux2 #(.WIDTH(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN_DATA  (IN_DATA),
    .IN_S     (IN_S),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .A_DATA   (A_DATA),
    .A_VALID  (A_VALID),
    .A_READY  (A_READY),
    .B_DATA   (B_DATA),
    .B_VALID  (B_VALID),
    .B_READY  (B_READY)
`ifdef STREAM_DEMUX2_CNT_EN
    ,
    .A_CNT    (A_CNT),
    .B_CNT    (B_CNT)
`endif
  );

  // 10-unit clock period.
  always #5 CLK = ~CLK;

  // Advance past the next rising edge so inputs can be driven safely.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reset held two cycles with a valid beat presented: nothing may be taken.
  task automatic test_reset();
    RST = 1'b1; IN_VALID = 1'b1; IN_S = 1'b0; IN_DATA = 8'h77;
    A_READY = 1'b0; B_READY = 1'b0;
    step(); step();
    #1;
    checks++; if (A_VALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_a_valid got=%0b exp=0", A_VALID); end
    checks++; if (B_VALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_b_valid got=%0b exp=0", B_VALID); end
    checks++; if (A_DATA !== 8'h00) begin errors++; $display("[TB] FAIL reset_a_data got=%0h exp=00", A_DATA); end
    checks++; if (B_DATA !== 8'h00) begin errors++; $display("[TB] FAIL reset_b_data got=%0h exp=00", B_DATA); end
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%0b exp=1", IN_READY); end
    RST = 1'b0; IN_VALID = 1'b0;
    step();
    #1;
    checks++; if (A_VALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_no_accept got=%0b exp=0", A_VALID); end
  endtask

  // Steering: 0x11->A, 0x22->B, 0x33->A with both consumers always ready.
  task automatic test_steering();
    A_READY = 1'b1; B_READY = 1'b1;
    IN_VALID = 1'b1; IN_S = 1'b0; IN_DATA = 8'h11;
    #1;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("[TB] FAIL steer_ready0 got=%0b exp=1", IN_READY); end
    step();
    IN_S = 1'b1; IN_DATA = 8'h22;
    #1;
    checks++; if (A_VALID !== 1'b1 || A_DATA !== 8'h11) begin errors++; $display("[TB] FAIL steer_a11 got=v%0b/%0h exp=v1/11", A_VALID, A_DATA); end
    checks++; if (B_VALID !== 1'b0) begin errors++; $display("[TB] FAIL steer_b_idle got=%0b exp=0", B_VALID); end
    step();
    IN_S = 1'b0; IN_DATA = 8'h33;
    #1;
    checks++; if (B_VALID !== 1'b1 || B_DATA !== 8'h22) begin errors++; $display("[TB] FAIL steer_b22 got=v%0b/%0h exp=v1/22", B_VALID, B_DATA); end
    checks++; if (A_VALID !== 1'b0) begin errors++; $display("[TB] FAIL steer_a_empty got=%0b exp=0", A_VALID); end
    step();
    IN_VALID = 1'b0;
    #1;
    checks++; if (A_VALID !== 1'b1 || A_DATA !== 8'h33) begin errors++; $display("[TB] FAIL steer_a33 got=v%0b/%0h exp=v1/33", A_VALID, A_DATA); end
    checks++; if (B_VALID !== 1'b0) begin errors++; $display("[TB] FAIL steer_b_drained got=%0b exp=0", B_VALID); end
    step();
    #1;
    checks++; if (A_VALID !== 1'b0) begin errors++; $display("[TB] FAIL steer_a_drained got=%0b exp=0", A_VALID); end
  endtask

  // Fill lane A, confirm backpressure, send a B beat past it, then drain A.
  task automatic test_full_and_drain();
    A_READY = 1'b0; B_READY = 1'b0;
    IN_VALID = 1'b1; IN_S = 1'b0; IN_DATA = 8'hA1;
    #1;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_a1 got=%0b exp=1", IN_READY); end
    step();
    IN_DATA = 8'hA2;
    #1;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_a2 got=%0b exp=1", IN_READY); end
    step();
    IN_DATA = 8'hA3;
    #1;
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("[TB] FAIL full_ready_a3 got=%0b exp=0", IN_READY); end
    checks++; if (A_VALID !== 1'b1 || A_DATA !== 8'hA1) begin errors++; $display("[TB] FAIL full_a_head got=v%0b/%0h exp=v1/a1", A_VALID, A_DATA); end
    step();
    #1;
    checks++; if (IN_READY !== 1'b0 || A_DATA !== 8'hA1) begin errors++; $display("[TB] FAIL full_hold got=r%0b/%0h exp=r0/a1", IN_READY, A_DATA); end
    IN_S = 1'b1; IN_DATA = 8'hB1;
    #1;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_b1 got=%0b exp=1", IN_READY); end
    step();
    IN_S = 1'b0; IN_DATA = 8'hA3;
    #1;
    checks++; if (B_VALID !== 1'b1 || B_DATA !== 8'hB1) begin errors++; $display("[TB] FAIL full_b1 got=v%0b/%0h exp=v1/b1", B_VALID, B_DATA); end
    checks++; if (A_DATA !== 8'hA1 || IN_READY !== 1'b0) begin errors++; $display("[TB] FAIL full_a_still got=%0h/r%0b exp=a1/r0", A_DATA, IN_READY); end
    A_READY = 1'b1;
    step();
    #1;
    checks++; if (A_DATA !== 8'hA2 || IN_READY !== 1'b1) begin errors++; $display("[TB] FAIL drain_a2 got=%0h/r%0b exp=a2/r1", A_DATA, IN_READY); end
    step();
    IN_VALID = 1'b0;
    #1;
    checks++; if (A_VALID !== 1'b1 || A_DATA !== 8'hA3) begin errors++; $display("[TB] FAIL drain_a3 got=v%0b/%0h exp=v1/a3", A_VALID, A_DATA); end
    step();
    #1;
    checks++; if (A_VALID !== 1'b0) begin errors++; $display("[TB] FAIL drain_a_empty got=%0b exp=0", A_VALID); end
    checks++; if (B_VALID !== 1'b1 || B_DATA !== 8'hB1) begin errors++; $display("[TB] FAIL drain_b_stall got=v%0b/%0h exp=v1/b1", B_VALID, B_DATA); end
    B_READY = 1'b1;
    step();
    #1;
    checks++; if (B_VALID !== 1'b0) begin errors++; $display("[TB] FAIL drain_b_empty got=%0b exp=0", B_VALID); end
  endtask

  // Push and pop on lane A at count 1: occupancy stays at one beat.
  task automatic test_push_pop_one();
    A_READY = 1'b0;
    IN_VALID = 1'b1; IN_S = 1'b0; IN_DATA = 8'h55;
    step();
    IN_DATA = 8'h66; A_READY = 1'b1;
    #1;
    checks++; if (A_DATA !== 8'h55 || IN_READY !== 1'b1) begin errors++; $display("[TB] FAIL pp_head55 got=%0h/r%0b exp=55/r1", A_DATA, IN_READY); end
    step();
    IN_VALID = 1'b0; A_READY = 1'b0;
    #1;
    checks++; if (A_VALID !== 1'b1 || A_DATA !== 8'h66) begin errors++; $display("[TB] FAIL pp_head66 got=v%0b/%0h exp=v1/66", A_VALID, A_DATA); end
    step();
    #1;
    checks++; if (A_VALID !== 1'b1 || A_DATA !== 8'h66) begin errors++; $display("[TB] FAIL pp_stall got=v%0b/%0h exp=v1/66", A_VALID, A_DATA); end
    A_READY = 1'b1;
    step();
    #1;
    checks++; if (A_VALID !== 1'b0) begin errors++; $display("[TB] FAIL pp_count_one got=%0b exp=0", A_VALID); end
  endtask

  // Reset while both lanes hold beats discards everything.
  task automatic test_reset_mid();
    A_READY = 1'b0; B_READY = 1'b0;
    IN_VALID = 1'b1; IN_S = 1'b0; IN_DATA = 8'hC1;
    step();
    IN_S = 1'b1; IN_DATA = 8'hC2;
    step();
    IN_VALID = 1'b0; RST = 1'b1;
    step();
    RST = 1'b0;
    #1;
    checks++; if (A_VALID !== 1'b0 || B_VALID !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_valid got=%0b%0b exp=00", A_VALID, B_VALID); end
    checks++; if (A_DATA !== 8'h00 || B_DATA !== 8'h00) begin errors++; $display("[TB] FAIL mid_reset_data got=%0h/%0h exp=00/00", A_DATA, B_DATA); end
  endtask

`ifdef STREAM_DEMUX2_CNT_EN
  // Pop counters: one B pop, 65535 A pops, then one more to wrap A.
  task automatic test_counters();
    RST = 1'b1; IN_VALID = 1'b0;
    step();
    RST = 1'b0;
    #1;
    checks++; if (A_CNT !== 16'd0 || B_CNT !== 16'd0) begin errors++; $display("[TB] FAIL cnt_reset got=%0h/%0h exp=0/0", A_CNT, B_CNT); end
    A_READY = 1'b1; B_READY = 1'b1;
    IN_VALID = 1'b1; IN_S = 1'b1; IN_DATA = 8'hBB;
    step();
    IN_VALID = 1'b0;
    step();
    #1;
    checks++; if (B_CNT !== 16'd1 || A_CNT !== 16'd0) begin errors++; $display("[TB] FAIL cnt_b_one got=%0h/%0h exp=0/1", A_CNT, B_CNT); end
    IN_VALID = 1'b1; IN_S = 1'b0; IN_DATA = 8'h5A;
    repeat (65535) step();
    IN_VALID = 1'b0;
    step();
    #1;
    checks++; if (A_CNT !== 16'hFFFF) begin errors++; $display("[TB] FAIL cnt_a_max got=%0h exp=ffff", A_CNT); end
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    step();
    #1;
    checks++; if (A_CNT !== 16'h0000) begin errors++; $display("[TB] FAIL cnt_a_wrap got=%0h exp=0", A_CNT); end
    checks++; if (B_CNT !== 16'd1) begin errors++; $display("[TB] FAIL cnt_b_unchanged got=%0h exp=1", B_CNT); end
    B_READY = 1'b0; IN_VALID = 1'b1; IN_S = 1'b1;
    step(); step();
    IN_VALID = 1'b0; B_READY = 1'b1;
    step(); step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    #1;
    checks++; if (A_CNT !== 16'd0 || B_CNT !== 16'd0) begin errors++; $display("[TB] FAIL cnt_rst_clear got=%0h/%0h exp=0/0", A_CNT, B_CNT); end
  endtask
`endif

  initial begin
    RST = 1'b1; IN_DATA = 8'h00; IN_S = 1'b0; IN_VALID = 1'b0;
    A_READY = 1'b0; B_READY = 1'b0;
    #1;
    $display("[TB] start");
    test_reset();
    test_steering();
    test_full_and_drain();
    test_push_pop_one();
    test_reset_mid();
`ifdef STREAM_DEMUX2_CNT_EN
    test_counters();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
